serial_word_rx: RTL and testbench



---
 rtl/serial_word_rx_if.sv | 30 +++
 rtl/serial_word_rx.sv | 141 ++++++++++++++
 tb/tb_serial_word_rx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_rx_if.sv
// Serial-in / parallel-out bus of serial_word_rx: serial bit stream plus the valid/ready word port.
// The master drives the serial bits and consumes words; the slave is the receiver.
interface serial_word_rx_if #(
    parameter int N = 8
);
    logic         sin;
    logic         sin_valid;
    logic         q_ready;
    logic [N-1:0] Q;
    logic         q_valid;
    logic         q_perr;

    modport master (
        output sin,
        output sin_valid,
        output q_ready,
        input  Q,
        input  q_valid,
        input  q_perr
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  q_ready,
        output Q,
        output q_valid,
        output q_perr
    );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver, LSB first, N bits into a one-entry valid/ready holding register.
// Latency: last bit to q_valid is 1 clock. Backpressure: never stalls the stream; a word completing
// while the held word is undrained is dropped and sets sticky overrun. Macro SERIAL_RX_PARITY_EN adds
// an even-parity bit after each word, reported on q_perr.
module serial_word_rx #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    serial_word_rx_if.slave     bus,
    output logic                busy,
    output logic [CW-1:0]       bit_count,
    output logic                overrun
);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic {SHIFT, PARITY} state_t;
`else
    typedef enum logic {SHIFT} state_t;
`endif

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state, state_n;
    logic [N-1:0]   sh, sh_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   q_reg, q_n;
    logic           q_vld, q_vld_n;
    logic           perr, perr_n;
    logic           ovr, ovr_n;

    logic [N-1:0]   sh_shift;
    logic [N-1:0]   word;
    logic           word_perr;
    logic           commit;
    logic           accept;
    logic           drain;
    logic           in_parity;

    assign sh_shift = {bus.sin, sh[N-1:1]};
    assign accept   = bus.sin_valid && !clear;
    assign drain    = q_vld && bus.q_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SHIFT;
            sh    <= '0;
            cnt   <= '0;
            q_reg <= '0;
            q_vld <= 1'b0;
            perr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            q_reg <= q_n;
            q_vld <= q_vld_n;
            perr  <= perr_n;
            ovr   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        cnt_n     = cnt;
        q_n       = q_reg;
        q_vld_n   = q_vld;
        perr_n    = perr;
        ovr_n     = ovr;
        commit    = 1'b0;
        word      = sh_shift;
        word_perr = 1'b0;

        // clear only touches the assembly side; the holding register keeps its word and handshake.
        if (clear) begin
            sh_n    = '0;
            cnt_n   = '0;
            state_n = SHIFT;
            ovr_n   = 1'b0;
        end else if (accept) begin
            case (state)
                SHIFT: begin
                    sh_n = sh_shift;
                    if (cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
                        cnt_n   = CW'(N);
`else
                        commit  = 1'b1;
                        cnt_n   = '0;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                // The parity bit is not shifted in; sh already holds the complete word.
                PARITY: begin
                    commit    = 1'b1;
                    word      = sh;
                    word_perr = (^sh) ^ bus.sin;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end
`endif
                default: state_n = SHIFT;
            endcase
        end

        // A drain in the commit cycle frees the slot, so the new word replaces the old one.
        if (commit) begin
            if (q_vld && !bus.q_ready) begin
                ovr_n = 1'b1;
            end else begin
                q_n     = word;
                perr_n  = word_perr;
                q_vld_n = 1'b1;
            end
        end else if (drain) begin
            q_vld_n = 1'b0;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    assign in_parity = (state == PARITY);
`else
    assign in_parity = 1'b0;
`endif

    assign busy        = (cnt != '0) || in_parity;
    assign bit_count   = cnt;
    assign overrun     = ovr;
    assign bus.Q       = q_reg;
    assign bus.q_valid = q_vld;
    assign bus.q_perr  = perr;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: a bit-indexed reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_serial_word_rx;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    serial_word_rx_if #(.N(N)) bus ();

    serial_word_rx #(.N(N), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .bus       (bus),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits are placed by index into an accumulator, word committed at count N.
    logic [N-1:0] m_q    = '0;
    logic [N-1:0] m_acc  = '0;
    bit           m_qv   = 1'b0;
    bit           m_perr = 1'b0;
    bit           m_ovr  = 1'b0;
    bit           m_pend = 1'b0;
    int           m_cnt  = 0;

    always @(posedge clock) begin
        bit           commit;
        bit           w_perr;
        logic [N-1:0] w;
        commit = 1'b0;
        w_perr = 1'b0;
        w      = '0;
        if (reset) begin
            m_q = '0; m_acc = '0; m_qv = 1'b0; m_perr = 1'b0;
            m_ovr = 1'b0; m_pend = 1'b0; m_cnt = 0;
        end else begin
            if (clear) begin
                m_cnt = 0; m_acc = '0; m_ovr = 1'b0; m_pend = 1'b0;
            end else if (bus.sin_valid) begin
                if (m_pend) begin
                    commit = 1'b1; w = m_acc; w_perr = ^{m_acc, bus.sin};
                    m_pend = 1'b0; m_cnt = 0; m_acc = '0;
                end else begin
                    m_acc[m_cnt] = bus.sin;
                    m_cnt++;
                    if (m_cnt == N) begin
`ifdef SERIAL_RX_PARITY_EN
                        m_pend = 1'b1;
`else
                        commit = 1'b1; w = m_acc; m_cnt = 0; m_acc = '0;
`endif
                    end
                end
            end
            if (commit) begin
                if (m_qv && !bus.q_ready) m_ovr = 1'b1;
                else begin m_q = w; m_perr = w_perr; m_qv = 1'b1; end
            end else if (m_qv && bus.q_ready) begin
                m_qv = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_q_valid", {31'd0, bus.q_valid}, {31'd0, m_qv});
            chk("model_Q", {24'd0, bus.Q}, {24'd0, m_q});
            chk("model_q_perr", {31'd0, bus.q_perr}, {31'd0, m_perr});
            chk("model_bit_count", {28'd0, bit_count}, m_cnt);
            chk("model_busy", {31'd0, busy}, {31'd0, (m_cnt != 0) || m_pend});
            chk("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        bus.q_ready   = rdy;
        tick();
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.q_ready   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w, input int maxgap, input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
            send_bit(w[i], rdy_last && (i == 7));
        end
    endtask

    task automatic drain();
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.q_ready = 1'b0;
        reset = 1'b1; clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_q_valid", {31'd0, bus.q_valid}, 32'd0);
        chk("reset_Q", {24'd0, bus.Q}, 32'd0);
        chk("reset_bit_count", {28'd0, bit_count}, 32'd0);

        // Basic receive of 0xA5
        send_byte(8'hA5, 0, 1'b0);
        chk("basic_Q", {24'd0, bus.Q}, 32'hA5);
        chk("basic_q_valid", {31'd0, bus.q_valid}, 32'd1);
        chk("basic_bit_count", {28'd0, bit_count}, 32'd0);
        chk("basic_busy", {31'd0, busy}, 32'd0);
        drain();
        chk("drain_q_valid", {31'd0, bus.q_valid}, 32'd0);

        // Gaps, then back-to-back with drain on the commit cycle
        send_byte(8'h3C, 2, 1'b0);
        chk("gaps_Q", {24'd0, bus.Q}, 32'h3C);
        send_byte(8'h81, 0, 1'b1);
        chk("b2b_Q", {24'd0, bus.Q}, 32'h81);
        chk("b2b_q_valid", {31'd0, bus.q_valid}, 32'd1);
        chk("b2b_overrun", {31'd0, overrun}, 32'd0);
        drain();

        // Overrun and clear
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        chk("ovr_Q", {24'd0, bus.Q}, 32'h11);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("ovr_clear_flag", {31'd0, overrun}, 32'd0);
        chk("ovr_clear_Q", {24'd0, bus.Q}, 32'h11);
        chk("ovr_clear_q_valid", {31'd0, bus.q_valid}, 32'd1);
        drain();

        // Clear mid-word, with a bit offered during the clear cycle
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        chk("mid_bit_count", {28'd0, bit_count}, 32'd3);
        clear = 1'b1; bus.sin = 1'b1; bus.sin_valid = 1'b1;
        tick();
        clear = 1'b0; bus.sin = 1'b0; bus.sin_valid = 1'b0;
        chk("clr_bit_count", {28'd0, bit_count}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hF0, 1, 1'b0);
        chk("clr_Q", {24'd0, bus.Q}, 32'hF0);
        drain();

        // Reset mid-operation with a held word, overrun set and partial word pending
        send_byte(8'h5A, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        pat = 8'h1D;
        for (int i = 0; i < 5; i++) send_bit(pat[i], 1'b0);
        chk("pre_rst_bit_count", {28'd0, bit_count}, 32'd5);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_Q", {24'd0, bus.Q}, 32'd0);
        chk("rst_q_valid", {31'd0, bus.q_valid}, 32'd0);
        chk("rst_bit_count", {28'd0, bit_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

`ifdef SERIAL_RX_PARITY_EN
        send_byte(8'h07, 0, 1'b0);
        chk("par_hold_count", {28'd0, bit_count}, 32'd8);
        chk("par_busy", {31'd0, busy}, 32'd1);
        chk("par_no_commit", {31'd0, bus.q_valid}, 32'd0);
        send_bit(1'b1, 1'b0);
        chk("par_ok_Q", {24'd0, bus.Q}, 32'h07);
        chk("par_ok_perr", {31'd0, bus.q_perr}, 32'd0);
        drain();
        send_byte(8'h07, 0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("par_bad_Q", {24'd0, bus.Q}, 32'h07);
        chk("par_bad_perr", {31'd0, bus.q_perr}, 32'd1);
        drain();
`else
        send_byte(8'h07, 0, 1'b0);
        pat = 8'h4B;
        send_bit(pat[0], 1'b1);
        chk("ninth_bit_count", {28'd0, bit_count}, 32'd1);
        chk("ninth_drained", {31'd0, bus.q_valid}, 32'd0);
        for (int i = 1; i < 8; i++) send_bit(pat[i], 1'b0);
        chk("ninth_next_Q", {24'd0, bus.Q}, 32'h4B);
        chk("ninth_perr", {31'd0, bus.q_perr}, 32'd0);
        drain();
`endif
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
